// File: rtl/serial_mag_compare_if.sv
// Operand/result bundle for the serial magnitude comparator.
// The master side issues start with operands; the slave side reports
// scan status and the eq/gt/lt verdict with the number of digits examined.
interface serial_mag_compare_if #(
    parameter int DIGITS = 4,
    parameter int CNTW   = 3
);
    logic                  start;
    logic [3*DIGITS-1:0]   a;
    logic [3*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic                  eq;
    logic                  gt;
    logic                  lt;
    logic [CNTW-1:0]       digits_used;

    modport master (
        output start, a, b,
        input  busy, done, eq, gt, lt, digits_used
    );

    modport slave (
        input  start, a, b,
        output busy, done, eq, gt, lt, digits_used
    );
endinterface

// File: rtl/serial_mag_compare.sv
// Sequential multi-digit magnitude comparator.
// Walks two operands of DIGITS 3-bit digits, most significant first, one
// digit per clock, and stops at the first unequal digit. The verdict and the
// number of digits examined are held until the next accepted start.
// DIGITS must lie in 1..(2^CNTW)-1 so digits_used can hold DIGITS.
module serial_mag_compare #(
    parameter int DIGITS = 4,
    parameter int CNTW   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_mag_compare_if.slave  bus
);

    localparam int W = 3 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_GT = 2'd1,
        CMP_LT = 2'd2
    } cmp_t;

    // Shared 3-bit digit slice: equal / greater / less, unsigned.
    function automatic cmp_t digit_cmp(input logic [2:0] x, input logic [2:0] y);
        if (x > y) begin
            return CMP_GT;
        end else if (x < y) begin
            return CMP_LT;
        end
        return CMP_EQ;
    endfunction

    state_t          state_q;
    state_t          state_d;

    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [CNTW-1:0] idx_q;

    logic            eq_q;
    logic            gt_q;
    logic            lt_q;
    logic [CNTW-1:0] du_q;

    logic            busy_o;
    logic            done_o;

    logic [2:0]      dig_a;
    logic [2:0]      dig_b;
    cmp_t            cmp_res;
    logic            last_digit;
    logic            accept;
    logic            decided;
    logic [CNTW-1:0] du_calc;

    // Start is only honoured when no scan is running (IDLE or the DONE cycle).
    assign accept = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Select the digit under examination from the latched operands.
    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == CNTW'(i)) begin
                dig_a = a_q[3*i +: 3];
                dig_b = b_q[3*i +: 3];
            end
        end
    end

    assign cmp_res    = digit_cmp(dig_a, dig_b);
    assign last_digit = (idx_q == '0);
    assign decided    = (state_q == ST_SCAN) && ((cmp_res != CMP_EQ) || last_digit);
    assign du_calc    = CNTW'(DIGITS) - idx_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: DONE may chain straight into SCAN on a new start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (decided) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = accept ? ST_SCAN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the registered state only.
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            ST_SCAN: busy_o = 1'b1;
            ST_DONE: done_o = 1'b1;
            default: begin
                busy_o = 1'b0;
                done_o = 1'b0;
            end
        endcase
    end

    // Operand latch, digit index and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            idx_q <= '0;
            eq_q  <= 1'b0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
            du_q  <= '0;
        end else if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            idx_q <= CNTW'(DIGITS - 1);
            eq_q  <= 1'b0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
            du_q  <= '0;
        end else if (state_q == ST_SCAN) begin
            if (decided) begin
                eq_q <= (cmp_res == CMP_EQ);
                gt_q <= (cmp_res == CMP_GT);
                lt_q <= (cmp_res == CMP_LT);
                du_q <= du_calc;
            end else begin
                idx_q <= idx_q - 1'b1;
            end
        end
    end

    assign bus.busy        = busy_o;
    assign bus.done        = done_o;
    assign bus.eq          = eq_q;
    assign bus.gt          = gt_q;
    assign bus.lt          = lt_q;
    assign bus.digits_used = du_q;

endmodule

// File: tb/tb_serial_mag_compare.sv
// Scoreboard bench for serial_mag_compare.
// The driver decides from its own model whether each start is accepted and,
// if so, queues the expected verdict with its issue and completion cycles.
// The monitor checks every cycle's outputs against the queue front.
module tb_serial_mag_compare;

    localparam int DIGITS = 4;
    localparam int CNTW   = 3;
    localparam int W      = 3 * DIGITS;

    typedef struct {
        int unsigned     e;
        int unsigned     d;
        logic            eq;
        logic            gt;
        logic            lt;
        logic [CNTW-1:0] du;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int unsigned cyc;
    int unsigned d_last;
    int unsigned n_vec;
    int unsigned n_err;
    exp_t        sb[$];
    logic [2+CNTW:0] hold;
    logic [4+CNTW:0] got_v;
    logic [4+CNTW:0] exp_v;

    serial_mag_compare_if #(.DIGITS(DIGITS), .CNTW(CNTW)) bus ();

    serial_mag_compare #(.DIGITS(DIGITS), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: integer compare; digits examined derive from the highest
    // differing bit of a^b (all digits when the operands are equal).
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t         r;
        logic [W-1:0] x;
        int           msb;
        x    = av ^ bv;
        r.e  = 0;
        r.d  = 0;
        r.eq = (av == bv);
        r.gt = (av > bv);
        r.lt = (av < bv);
        msb  = -1;
        for (int i = 0; i < W; i++) begin
            if (x[i]) msb = i;
        end
        if (msb < 0) r.du = CNTW'(DIGITS);
        else         r.du = CNTW'(DIGITS - msb / 3);
        return r;
    endfunction

    // Drive one start pulse at a falling edge; queue it only if accepted.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t        r;
        int unsigned e;
        e         = cyc + 1;
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        if (e > d_last) begin
            r   = model(av, bv);
            r.e = e;
            r.d = e + int'(r.du);
            sb.push_back(r);
            d_last = r.d;
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: per-cycle expectation from the scoreboard front.
    always @(negedge clk) begin
        if (rst_n) begin
            got_v = {bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.digits_used};
            if (sb.size() > 0 && cyc >= sb[0].e && cyc < sb[0].d) begin
                exp_v = {1'b1, 1'b0, 3'b000, {CNTW{1'b0}}};
            end else if (sb.size() > 0 && cyc == sb[0].d) begin
                hold  = {sb[0].eq, sb[0].gt, sb[0].lt, sb[0].du};
                exp_v = {1'b0, 1'b1, hold};
                void'(sb.pop_front());
            end else begin
                exp_v = {2'b00, hold};
            end
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL outputs cycle %0d: busy,done,eq,gt,lt,du got %b expected %b",
                         cyc, got_v, exp_v);
            end
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int unsigned  k;
        int unsigned  guard;

        cyc       = 0;
        d_last    = 0;
        n_vec     = 0;
        n_err     = 0;
        hold      = '0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        idle(3);
        n_vec++;
        if ({bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.digits_used} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got %b expected all zero",
                     {bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.digits_used});
        end
        rst_n = 1'b1;
        idle(2);

        // Equal operands scan every digit.
        issue(12'o7531, 12'o7531);
        idle(8);
        // Top digit decides immediately.
        issue(12'o7531, 12'o6531);
        idle(4);
        // Third digit decides; result then held through idle cycles.
        issue(12'o7521, 12'o7531);
        idle(14);
        // Second start during the scan must be ignored.
        issue(12'o0000, 12'o0001);
        issue(12'o7777, 12'o7777);
        idle(6);
        // Back-to-back: start held in the DONE cycle.
        issue(12'o7000, 12'o6000);
        guard = 0;
        while (cyc < d_last && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        issue(12'o1234, 12'o1234);
        idle(7);

        // Asynchronous reset in the second busy cycle of an equal scan.
        issue(12'o0123, 12'o0123);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.digits_used} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got %b expected all zero",
                     {bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.digits_used});
        end
        sb.delete();
        hold   = '0;
        d_last = 0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        issue(12'o4444, 12'o4443);
        idle(7);

        // Randomised traffic; short gaps make some starts land mid-scan.
        for (int t = 0; t < 80; t++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0: rb = ra;
                1: begin
                    k  = $urandom_range(0, DIGITS - 1);
                    rb = ra;
                    rb[3*k +: 3] = ra[3*k +: 3] ^ 3'($urandom_range(1, 7));
                    for (int unsigned j = 0; j < k; j++) begin
                        rb[3*j +: 3] = 3'($urandom);
                    end
                end
                default: rb = W'($urandom);
            endcase
            issue(ra, rb);
            idle($urandom_range(0, 5));
        end

        guard = 0;
        while (sb.size() > 0 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
